// File: rtl/wishbone_slave_if.sv
// Wishbone bus bundle between a single master and the SD-host register slave.
// The master holds strobe_i until it sees ack_o; the slave answers each strobe assertion with exactly one ack_o pulse.
interface wishbone_slave_if;
  logic        strobe_i;
  logic        we_i;
  logic        adr_i;
  logic [63:0] wb_data_i;
  logic        ack_o;
  logic [63:0] wb_data_o;

  modport slave (
    input  strobe_i,
    input  we_i,
    input  adr_i,
    input  wb_data_i,
    output ack_o,
    output wb_data_o
  );

  modport master (
    output strobe_i,
    output we_i,
    output adr_i,
    output wb_data_i,
    input  ack_o,
    input  wb_data_o
  );
endinterface

// File: rtl/wishbone_slave.sv
// Wishbone slave front-end for an SD engine: a command latch, a TX FIFO toward the engine and an RX FIFO from it.
// SD-side handshakes: a word moves on a clock edge where valid and ready are both high; valid never waits on ready.
module wishbone_slave #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  wishbone_slave_if.slave   wb,
  output logic [63:0]       cmd_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ack_i,
  output logic [63:0]       tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [63:0]       rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT_RELEASE = 2'd2} state_t;

  state_t      state;
  logic [63:0] tx_mem [FIFO_DEPTH];
  logic [63:0] rx_mem [FIFO_DEPTH];
  logic [1:0]  tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [2:0]  tx_count, rx_count;

  logic idle_req, cmd_wr, tx_push, tx_pop, rx_push, rx_pop, stat_rd, serviced;

  // Every bus-side FIFO/command effect happens on the single IDLE->ACK edge.
  assign idle_req = (state == IDLE) && wb.strobe_i;
  assign cmd_wr   = idle_req &&  wb.we_i && !wb.adr_i && !cmd_valid_o;
  assign tx_push  = idle_req &&  wb.we_i &&  wb.adr_i && (tx_count != 3'(FIFO_DEPTH));
  assign rx_pop   = idle_req && !wb.we_i &&  wb.adr_i && (rx_count != 3'd0);
  assign stat_rd  = idle_req && !wb.we_i && !wb.adr_i;
  assign serviced = cmd_wr || tx_push || rx_pop || stat_rd;

  assign tx_valid_o = (tx_count != 3'd0);
  assign rx_ready_o = (rx_count != 3'(FIFO_DEPTH));
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign rx_push    = rx_valid_i && rx_ready_o;
  assign tx_data_o  = tx_mem[tx_rptr];
  assign dbg_state  = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wb.ack_o     <= 1'b0;
      wb.wb_data_o <= 64'd0;
      cmd_o        <= 64'd0;
      cmd_valid_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (serviced) begin
            state    <= ACK;
            wb.ack_o <= 1'b1;
          end
        end
        ACK: begin
          state    <= WAIT_RELEASE;
          wb.ack_o <= 1'b0;
        end
        WAIT_RELEASE: begin
          if (!wb.strobe_i) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          wb.ack_o <= 1'b0;
        end
      endcase

      // A write needs cmd_valid_o low, so it never meets a live cmd_ack_i.
      if (cmd_wr) begin
        cmd_o       <= wb.wb_data_i;
        cmd_valid_o <= 1'b1;
      end else if (cmd_ack_i) begin
        cmd_valid_o <= 1'b0;
      end

      if (rx_pop)
        wb.wb_data_o <= rx_mem[rx_rptr];
      else if (stat_rd)
        wb.wb_data_o <= {57'd0, rx_count, tx_count, cmd_valid_o};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wptr  <= 2'd0;
      tx_rptr  <= 2'd0;
      tx_count <= 3'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= 64'd0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= wb.wb_data_i;
        tx_wptr         <= tx_wptr + 2'd1;
      end
      if (tx_pop) tx_rptr <= tx_rptr + 2'd1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 3'd1;
        2'b01:   tx_count <= tx_count - 3'd1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wptr  <= 2'd0;
      rx_rptr  <= 2'd0;
      rx_count <= 3'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= 64'd0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr] <= rx_data_i;
        rx_wptr         <= rx_wptr + 2'd1;
      end
      if (rx_pop) rx_rptr <= rx_rptr + 2'd1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 3'd1;
        2'b01:   rx_count <= rx_count - 3'd1;
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_slave.sv
// Bench for wishbone_slave: directed scenarios plus random operations checked against a queue-based model.
module tb_wishbone_slave;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  wishbone_slave_if bus();

  logic [63:0] cmd_o;
  logic        cmd_valid_o;
  logic        cmd_ack_i = 1'b0;
  logic [63:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [63:0] rx_data_i = 64'd0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [1:0]  dbg_state;

  wishbone_slave #(.FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .wb          (bus),
    .cmd_o       (cmd_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ack_i   (cmd_ack_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .dbg_state   (dbg_state)
  );

  // reference model: transaction-level queues
  logic [63:0] tx_q[$];
  logic [63:0] rx_q[$];
  bit          cmd_pend;
  logic [63:0] cmd_word;
  logic [63:0] last_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit model_ok(input bit we, input bit adr);
    case ({we, adr})
      2'b10:   return !cmd_pend;
      2'b11:   return tx_q.size() < 4;
      2'b01:   return rx_q.size() > 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, "/tx_valid"}, 64'(tx_valid_o), 64'(tx_q.size() != 0));
    if (tx_q.size() != 0) check({tag, "/tx_head"}, tx_data_o, tx_q[0]);
    check({tag, "/rx_ready"}, 64'(rx_ready_o), 64'(rx_q.size() < 4));
    check({tag, "/cmd_valid"}, 64'(cmd_valid_o), 64'(cmd_pend));
    if (cmd_pend) check({tag, "/cmd_o"}, cmd_o, cmd_word);
    check({tag, "/rd_hold"}, bus.wb_data_o, last_rd);
    check({tag, "/ack_idle"}, 64'(bus.ack_o), 64'd0);
  endtask

  // driver: one bus access; pop_too raises tx_ready_i on the first edge only
  task automatic wb_access(input bit we, input bit adr, input logic [63:0] data,
                           input bit pop_too, input int hold);
    bit          exp_ok;
    logic [63:0] exp_rd;
    int          waited;
    bit          got;
    int          budget;
    exp_ok = model_ok(we, adr);
    exp_rd = last_rd;
    if (!we && !adr) exp_rd = {57'd0, 3'(rx_q.size()), 3'(tx_q.size()), cmd_pend};
    if (!we && adr && rx_q.size() > 0) exp_rd = rx_q[0];
    bus.strobe_i  = 1'b1;
    bus.we_i      = we;
    bus.adr_i     = adr;
    bus.wb_data_i = data;
    tx_ready_i    = pop_too;
    waited = 0;
    got    = 1'b0;
    budget = exp_ok ? 4 : 3;
    while (!got && waited < budget) begin
      tick();
      tx_ready_i = 1'b0;
      waited++;
      if (bus.ack_o) got = 1'b1;
    end
    if (pop_too && tx_q.size() > 0) void'(tx_q.pop_front());
    if (exp_ok) begin
      check("ack_seen", 64'(got), 64'd1);
      check("ack_latency", 64'(waited), 64'd1);
      if (!we) check("rd_data", bus.wb_data_o, exp_rd);
      else     check("wr_rd_hold", bus.wb_data_o, last_rd);
      if (!we) last_rd = exp_rd;
      if (we && !adr) begin cmd_pend = 1'b1; cmd_word = data; end
      if (we && adr)  tx_q.push_back(data);
      if (!we && adr) void'(rx_q.pop_front());
    end else begin
      check("stall_no_ack", 64'(got), 64'd0);
    end
    if (got) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check("one_ack_per_strobe", 64'(bus.ack_o), 64'd0);
      end
    end
    bus.strobe_i = 1'b0;
    tick();
    check("ack_released", 64'(bus.ack_o), 64'd0);
    tick();
  endtask

  task automatic sd_pop();
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    if (tx_q.size() > 0) void'(tx_q.pop_front());
  endtask

  task automatic sd_push(input logic [63:0] d);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    tick();
    rx_valid_i = 1'b0;
    if (rx_q.size() < 4) rx_q.push_back(d);
  endtask

  task automatic sd_cmd_ack();
    cmd_ack_i = 1'b1;
    tick();
    cmd_ack_i = 1'b0;
    cmd_pend  = 1'b0;
  endtask

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    cmd_pend = 1'b0;
    cmd_word = 64'd0;
    last_rd  = 64'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/state"}, 64'(dbg_state), 64'd0);
    check({tag, "/ack"}, 64'(bus.ack_o), 64'd0);
    check({tag, "/rdata"}, bus.wb_data_o, 64'd0);
    check({tag, "/cmd_o"}, cmd_o, 64'd0);
    check({tag, "/cmd_valid"}, 64'(cmd_valid_o), 64'd0);
    check({tag, "/tx_valid"}, 64'(tx_valid_o), 64'd0);
    check({tag, "/rx_ready"}, 64'(rx_ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.strobe_i  = 1'b0;
    bus.we_i      = 1'b0;
    bus.adr_i     = 1'b0;
    bus.wb_data_i = 64'd0;
    model_clear();

    #12;
    check_reset_values("por");
    reset = 1'b1;
    tick();

    // command latch and acknowledge
    wb_access(1'b1, 1'b0, 64'h1234, 1'b0, 0);
    check_state("cmd_wr");
    check("cmd_value", cmd_o, 64'h1234);
    wb_access(1'b1, 1'b0, 64'h5555, 1'b0, 0);
    check_state("cmd_busy");
    sd_cmd_ack();
    check_state("cmd_acked");
    sd_cmd_ack();
    check_state("cmd_ack_idle");

    // TX fill to full, fifth write stalls until a pop
    for (int i = 1; i <= 5; i++) wb_access(1'b1, 1'b1, 64'(i), 1'b0, 0);
    check_state("tx_full");
    wb_access(1'b0, 1'b0, 64'd0, 1'b0, 2);
    check("status_full", bus.wb_data_o, 64'h08);
    check("tx_head_1", tx_data_o, 64'd1);
    sd_pop();
    wb_access(1'b1, 1'b1, 64'd5, 1'b0, 0);
    check_state("tx_after_5th");
    for (int i = 0; i < 5; i++) begin sd_pop(); check_state("tx_drain"); end

    // RX push/read, third read waits for a fresh push
    sd_push(64'hA);
    sd_push(64'hB);
    wb_access(1'b0, 1'b1, 64'd0, 1'b0, 0);
    check("rx_first", bus.wb_data_o, 64'hA);
    wb_access(1'b0, 1'b1, 64'd0, 1'b0, 0);
    check("rx_second", bus.wb_data_o, 64'hB);
    bus.strobe_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("rx_empty_stall", 64'(bus.ack_o), 64'd0); end
    rx_valid_i = 1'b1; rx_data_i = 64'hC;
    tick();
    rx_valid_i = 1'b0;
    check("rx_push_edge_no_ack", 64'(bus.ack_o), 64'd0);
    tick();
    check("rx_late_ack", 64'(bus.ack_o), 64'd1);
    check("rx_late_data", bus.wb_data_o, 64'hC);
    last_rd = 64'hC;
    bus.strobe_i = 1'b0;
    tick(); tick();
    check_state("rx_done");

    // simultaneous push and pop at count 2
    wb_access(1'b1, 1'b1, 64'd1, 1'b0, 0);
    wb_access(1'b1, 1'b1, 64'd2, 1'b0, 0);
    wb_access(1'b1, 1'b1, 64'd3, 1'b1, 0);
    wb_access(1'b0, 1'b0, 64'd0, 1'b0, 0);
    check("status_pushpop", bus.wb_data_o, 64'h04);
    check_state("pushpop");
    sd_pop(); sd_pop();
    check_state("pushpop_drain");

    // pointer wrap: ten writes interleaved with pops
    for (int i = 1; i <= 10; i++) begin
      wb_access(1'b1, 1'b1, 64'(i), 1'b0, 0);
      if (i >= 3) begin check_state("wrap"); sd_pop(); end
    end
    while (tx_q.size() > 0) begin check_state("wrap_drain"); sd_pop(); end
    check_state("wrap_end");

    // reset during ACK
    wb_access(1'b1, 1'b1, 64'h77, 1'b0, 0);
    sd_push(64'h99);
    bus.strobe_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 1'b0; bus.wb_data_i = 64'hDEAD;
    tick();
    check("pre_reset_ack", 64'(bus.ack_o), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    bus.strobe_i = 1'b0;
    #3;
    reset = 1'b1;
    model_clear();
    tick(); tick();
    check_state("post_reset");

    // random operations
    for (int n = 0; n < 300; n++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: wb_access(1'b1, 1'b0, d, 1'b0, $urandom_range(0, 2));
        1: wb_access(1'b1, 1'b1, d, 1'b0, $urandom_range(0, 2));
        2: wb_access(1'b0, 1'b1, d, 1'b0, $urandom_range(0, 2));
        3: wb_access(1'b0, 1'b0, d, 1'b0, $urandom_range(0, 2));
        4: sd_pop();
        5: sd_push(d);
        default: sd_cmd_ack();
      endcase
      check_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_slave.md
WISHBONE_SLAVE -- requirements
Module: wishbone_slave

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the entry count of each data FIFO; it SHALL be fixed at 4 (2-bit pointers).
REQ-003 Port clock, input, 1: rising-edge clock for all state.
REQ-004 Port reset, input, 1: asynchronous, active-low; 0 clears all state.
REQ-005 Port strobe_i, input, 1: Wishbone cycle request from master.
REQ-006 Port we_i, input, 1: 1 = write to SD side, 0 = read from SD side.
REQ-007 Port adr_i, input, 1: 0 = command/status space, 1 = data space.
REQ-008 Port wb_data_i, input, 64: write data from master.
REQ-009 Port ack_o, output, 1: one-cycle transfer acknowledge to master.
REQ-010 Port wb_data_o, output, 64: read data to master, valid while ack_o = 1.
REQ-011 Port cmd_o, output, 64: latched command word toward SD engine.
REQ-012 Port cmd_valid_o, output, 1: command pending.
REQ-013 Port cmd_ack_i, input, 1: SD engine consumed the command.
REQ-014 Port tx_data_o, output, 64: head of TX FIFO.
REQ-015 Port tx_valid_o, output, 1: TX FIFO not empty.
REQ-016 Port tx_ready_i, input, 1: SD engine pops TX head when tx_valid_o & tx_ready_i.
REQ-017 Port rx_data_i, input, 64: data word from SD engine.
REQ-018 Port rx_valid_i, input, 1: rx_data_i valid.
REQ-019 Port rx_ready_o, output, 1: RX FIFO not full; push on rx_valid_i & rx_ready_o.

Function
REQ-020 Bus FSM states SHALL be IDLE, ACK, WAIT_RELEASE.
REQ-021 IDLE: strobe_i = 1 with access serviceable -> perform access, go to ACK; not serviceable -> stay IDLE (stall, ack_o = 0).
REQ-022 Serviceable: cmd write (we=1, adr=0) needs cmd_valid_o = 0; data write (we=1, adr=1) needs TX not full; data read (we=0, adr=1) needs RX not empty; status read (we=0, adr=0) always.
REQ-023 ACK: ack_o = 1 for exactly one cycle; next state WAIT_RELEASE.
REQ-024 WAIT_RELEASE: ack_o = 0; go to IDLE on the first cycle strobe_i = 0; one access per strobe assertion.
REQ-025 Latency: strobe_i sampled high at edge N with access serviceable -> ack_o high during cycle N+1.
REQ-026 Cmd write: cmd_o <= wb_data_i, cmd_valid_o <= 1 at edge N; cmd_valid_o clears on the edge where cmd_ack_i = 1.
REQ-027 Data write: push wb_data_i to TX FIFO at edge N; data read: pop RX head into wb_data_o at edge N.
REQ-028 Status read: wb_data_o = {57'b0, rx_count[2:0], tx_count[2:0], cmd_valid_o}; counts range 0..4.
REQ-029 wb_data_o SHALL hold its last value outside ACK.
REQ-030 FIFOs: 2-bit read/write pointers wrap 3 -> 0; 3-bit count; simultaneous push and pop leave count unchanged, both pointers advance.
REQ-031 TX pop while empty and RX push while full SHALL be ignored (no pointer or count change).
REQ-032 Cmd write and cmd_ack_i in the same cycle cannot collide (write requires cmd_valid_o = 0); cmd_ack_i while cmd_valid_o = 0 is ignored.
REQ-033 adr_i, we_i, wb_data_i are sampled only at the IDLE->ACK edge.

Reset
REQ-034 reset = 0 SHALL immediately force state IDLE, ack_o = 0, wb_data_o = 0, cmd_o = 0, cmd_valid_o = 0, both FIFOs empty (tx_valid_o = 0, rx_ready_o = 1), pointers 0.
REQ-035 Reset asserted mid-access (ACK or WAIT_RELEASE) SHALL abort it; no ack after release; FIFO contents lost.

Verification
REQ-036 Cmd: write 64'h1234 to adr 0 -> ack_o one cycle after strobe, cmd_o = 64'h1234, cmd_valid_o = 1; cmd_ack_i pulse -> cmd_valid_o = 0.
REQ-037 TX full: 5 data writes 1..5, tx_ready_i = 0 -> writes 1-4 acked, 5th stalls; status = 64'h08; one pop (tx_data_o = 1) -> 5th acked next cycle.
REQ-038 RX: push 64'hA, 64'hB via rx_valid_i; two data reads -> wb_data_o = A then B; 3rd read stalls until a new push.
REQ-039 Wrap: 10 writes interleaved with pops -> tx_data_o order 1..10, count never exceeds 4.
REQ-040 Simultaneous TX push and pop at count 2 -> count stays 2; status read returns 64'h04.
REQ-041 Reset asserted during ACK -> ack_o drops immediately, all outputs at reset values, rx_ready_o = 1.
